// File: rtl/mc_control_if.sv
// Control bus between the multicycle controller and its datapath.
// master: the controller (decode inputs and flags in, datapath controls out).
// slave:  the datapath (controls in, instruction fields and flags out).
interface mc_control_if;
    logic [5:0] opcode;      // instruction bits [31:26]
    logic [5:0] funct;       // instruction bits [5:0]
    logic       Zero;        // ALU zero flag, same cycle
    logic       mem_ready;   // memory access completes this cycle
    logic [3:0] ALUCtrl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic [1:0] PCSrc;
    logic       pc_en;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output ALUCtrl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal_op,
               instr_done, state
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  ALUCtrl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal_op,
               instr_done, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-subset main controller (Moore FSM).
// Ports: clk, rst (synchronous, active high), bus (mc_control_if.master):
//   opcode/funct/Zero/mem_ready in; ALU, mux, memory, register-file and PC
//   controls out, plus illegal_op/instr_done pulses and the state for debug.
module mc_control (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);
    localparam int unsigned ST_W  = 4;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;

    typedef enum logic [ST_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

    state_t            state_q;
    state_t            state_d;
    logic [ALU_W-1:0]  alu_ctrl;
    logic              src_a;
    logic [1:0]        src_b;
    logic              iord;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              reg_write;
    logic [1:0]        pc_src;
    logic              pc_write;
    logic              branch;
    logic              illegal;
    logic              done;
    logic              funct_ok;
    logic [ALU_W-1:0]  funct_alu;

    // Supported R-type functions and their ALU operation
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            6'h00:   funct_alu = ALU_SLL;
            6'h02:   funct_alu = ALU_SRL;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state controls
    always_comb begin
        state_d    = FETCH;
        alu_ctrl   = ALU_ADD;
        src_a      = 1'b0;
        src_b      = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        done       = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                src_b    = 2'b01;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
                state_d  = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_RTYPE: begin
                        state_d = funct_ok ? EXEC : FETCH;
                        illegal = ~funct_ok;
                    end
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                done       = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                done      = bus.mem_ready;
                state_d   = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                src_a    = 1'b1;
                alu_ctrl = funct_alu;
                state_d  = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            BRANCH: begin
                src_a    = 1'b1;
                alu_ctrl = ALU_SUB;
                pc_src   = 2'b01;
                branch   = 1'b1;
                done     = 1'b1;
            end
            ADDIEX: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset presents FETCH controls immediately, with all enables and pulses quiet
        if (rst) begin
            state_d    = FETCH;
            alu_ctrl   = ALU_ADD;
            src_a      = 1'b0;
            src_b      = 2'b01;
            iord       = 1'b0;
            mem_read   = 1'b1;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            pc_src     = 2'b00;
            pc_write   = 1'b0;
            branch     = 1'b0;
            illegal    = 1'b0;
            done       = 1'b0;
        end
    end

    assign bus.ALUCtrl    = alu_ctrl;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.IorD       = iord;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.PCSrc      = pc_src;
    assign bus.pc_en      = pc_write | (branch & bus.Zero);
    assign bus.illegal_op = illegal;
    assign bus.instr_done = done;
    assign bus.state      = ST_W'(state_q);
endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver applies one cycle of inputs and
// queues the expected control word; the monitor compares on the falling edge.
module tb_mc_control;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SLL = 4'b0100;
    localparam logic [3:0] A_SRL = 4'b0101;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic clk;
    logic rst;
    mc_control_if bus ();

    mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] exp_q[$];
    string       tag_q[$];
    int          checks;
    int          errors;

    // Expected control word; static fields come from the per-state table
    function automatic logic [22:0] ew(input logic r, input logic [3:0] st,
                                       input logic [3:0] alu, input logic pcen,
                                       input logic ir, input logic ill,
                                       input logic dn);
        logic [3:0] ls;
        logic       sa, iord, mrd, mwr, rdst, m2r, rw;
        logic [1:0] sb, pcs;
        ls = r ? 4'd0 : st;
        sa = 0; iord = 0; mrd = 0; mwr = 0; rdst = 0; m2r = 0; rw = 0;
        sb = 2'b00; pcs = 2'b00;
        case (ls)
            4'd0:  begin mrd = 1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin iord = 1; mrd = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iord = 1; mwr = 1; end
            4'd6:  sa = 1;
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin sa = 1; pcs = 2'b01; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: pcs = 2'b10;
            default: ;
        endcase
        return {alu, sa, sb, iord, mrd, mwr, ir, rdst, m2r, rw, pcs, pcen, ill, dn, st};
    endfunction

    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic mr,
                        input logic [3:0] st, input logic [3:0] alu,
                        input logic pcen, input logic ir, input logic ill,
                        input logic dn);
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.Zero      = z;
        bus.mem_ready = mr;
        exp_q.push_back(ew(r, st, alu, pcen, ir, ill, dn));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // R-type with no memory wait: FETCH, DECODE, EXEC, ALUWB
    task automatic r_instr(input string tag, input logic [5:0] fn, input logic [3:0] alu);
        step({tag, "_f"}, 0, 6'h00, fn, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step({tag, "_d"}, 0, 6'h00, fn, 1, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step({tag, "_e"}, 0, 6'h00, fn, 0, 1, 4'd6, alu,   0, 0, 0, 0);
        step({tag, "_w"}, 0, 6'h3F, 6'h18, 1, 1, 4'd7, A_ADD, 0, 0, 0, 1);
    endtask

    // Monitor: every cycle with a queued expectation is compared
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [22:0] exp_w, act_w;
            string       t;
            exp_w = exp_q.pop_front();
            t     = tag_q.pop_front();
            act_w = {bus.ALUCtrl, bus.ALUSrcA, bus.ALUSrcB, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                     bus.RegWrite, bus.PCSrc, bus.pc_en, bus.illegal_op,
                     bus.instr_done, bus.state};
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL %s: got %06h expected %06h", t, act_w, exp_w);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Held in reset: FETCH controls, enables gated despite mem_ready
        step("rst_hold", 1, 6'h00, 6'h20, 1, 1, 4'd0, A_ADD, 0, 0, 0, 0);

        // add
        r_instr("add", 6'h20, A_ADD);

        // lw: one FETCH wait, two MEMRD waits, opcode wiggled where unsampled
        step("lw_fwait", 0, 6'h23, 6'h00, 0, 0, 4'd0, A_ADD, 0, 0, 0, 0);
        step("lw_f",     0, 6'h23, 6'h00, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("lw_d",     0, 6'h23, 6'h00, 0, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step("lw_a",     0, 6'h23, 6'h00, 0, 1, 4'd2, A_ADD, 0, 0, 0, 0);
        step("lw_r0",    0, 6'h2B, 6'h00, 0, 0, 4'd3, A_ADD, 0, 0, 0, 0);
        step("lw_r1",    0, 6'h3F, 6'h00, 0, 0, 4'd3, A_ADD, 0, 0, 0, 0);
        step("lw_r2",    0, 6'h23, 6'h00, 0, 1, 4'd3, A_ADD, 0, 0, 0, 0);
        step("lw_wb",    0, 6'h23, 6'h00, 0, 0, 4'd4, A_ADD, 0, 0, 0, 1);

        // sw with one MEMWR wait
        step("sw_f",  0, 6'h2B, 6'h00, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("sw_d",  0, 6'h2B, 6'h00, 0, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step("sw_a",  0, 6'h2B, 6'h00, 0, 1, 4'd2, A_ADD, 0, 0, 0, 0);
        step("sw_w0", 0, 6'h2B, 6'h00, 0, 0, 4'd5, A_ADD, 0, 0, 0, 0);
        step("sw_w1", 0, 6'h2B, 6'h00, 0, 1, 4'd5, A_ADD, 0, 0, 0, 1);

        // beq taken then not taken
        step("beq1_f", 0, 6'h04, 6'h00, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("beq1_d", 0, 6'h04, 6'h00, 1, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step("beq1_b", 0, 6'h04, 6'h00, 1, 1, 4'd8, A_SUB, 1, 0, 0, 1);
        step("beq0_f", 0, 6'h04, 6'h00, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("beq0_d", 0, 6'h04, 6'h00, 0, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step("beq0_b", 0, 6'h04, 6'h00, 0, 1, 4'd8, A_SUB, 0, 0, 0, 1);

        // addi
        step("addi_f", 0, 6'h08, 6'h00, 0, 1, 4'd0,  A_ADD, 1, 1, 0, 0);
        step("addi_d", 0, 6'h08, 6'h00, 0, 1, 4'd1,  A_ADD, 0, 0, 0, 0);
        step("addi_e", 0, 6'h08, 6'h00, 0, 1, 4'd9,  A_ADD, 0, 0, 0, 0);
        step("addi_w", 0, 6'h08, 6'h00, 0, 1, 4'd10, A_ADD, 0, 0, 0, 1);

        // j
        step("j_f", 0, 6'h02, 6'h00, 0, 1, 4'd0,  A_ADD, 1, 1, 0, 0);
        step("j_d", 0, 6'h02, 6'h00, 0, 1, 4'd1,  A_ADD, 0, 0, 0, 0);
        step("j_j", 0, 6'h02, 6'h00, 0, 1, 4'd11, A_ADD, 1, 0, 0, 1);

        // illegal opcode, then unsupported R-type funct
        step("ill_op_f", 0, 6'h3F, 6'h20, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("ill_op_d", 0, 6'h3F, 6'h20, 0, 1, 4'd1, A_ADD, 0, 0, 1, 0);
        step("ill_fn_f", 0, 6'h00, 6'h18, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("ill_fn_d", 0, 6'h00, 6'h18, 0, 1, 4'd1, A_ADD, 0, 0, 1, 0);

        // ALU function sweep
        r_instr("slt", 6'h2A, A_SLT);
        r_instr("sll", 6'h00, A_SLL);
        r_instr("srl", 6'h02, A_SRL);
        r_instr("or",  6'h25, A_OR);
        r_instr("and", 6'h24, A_AND);
        r_instr("sub", 6'h22, A_SUB);

        // Reset during a stalled store, then an immediate clean fetch
        step("swr_f",   0, 6'h2B, 6'h00, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("swr_d",   0, 6'h2B, 6'h00, 0, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step("swr_a",   0, 6'h2B, 6'h00, 0, 1, 4'd2, A_ADD, 0, 0, 0, 0);
        step("swr_w",   0, 6'h2B, 6'h00, 0, 0, 4'd5, A_ADD, 0, 0, 0, 0);
        step("swr_rst", 1, 6'h2B, 6'h00, 0, 0, 4'd5, A_ADD, 0, 0, 0, 0);
        step("post_f",  0, 6'h02, 6'h00, 0, 1, 4'd0, A_ADD, 1, 1, 0, 0);
        step("post_d",  0, 6'h02, 6'h00, 0, 1, 4'd1, A_ADD, 0, 0, 0, 0);
        step("post_j",  0, 6'h02, 6'h00, 0, 1, 4'd11, A_ADD, 1, 0, 0, 1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; all widths fixed as below.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction register bits [31:26].
REQ-005 funct  input  6  instruction register bits [5:0].
REQ-006 Zero  input  1  ALU zero flag, same cycle.
REQ-007 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-008 ALUCtrl  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0100 SLL, 0101 SRL.
REQ-009 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-010 ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-011 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite  output  1 each  standard multicycle datapath controls.
REQ-012 PCSrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-013 pc_en  output  1  PC write enable = PCWrite | (Branch & Zero).
REQ-014 illegal_op  output  1  one-cycle pulse on unsupported opcode/funct.
REQ-015 instr_done  output  1  one-cycle pulse in the final state of each retired instruction.
REQ-016 state  output  4  current state encoding, for debug.

Function
REQ-017 SHALL be a Moore FSM; all outputs except pc_en, IRWrite and mem_ready-qualified enables depend only on state.
REQ-018 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; encodings 12-15 SHALL go to FETCH next cycle.
REQ-019 Defaults in every state unless listed: all enables 0, all selects 0, ALUCtrl 0010.
REQ-020 FETCH: MemRead=1, ALUSrcB=01, ALUCtrl ADD; IRWrite=pc_en=mem_ready; stay until mem_ready, then DECODE.
REQ-021 DECODE: ALUSrcB=11, ALUCtrl ADD; next: lw 0x23/sw 0x2B -> MEMADR; R-type 0x00 with supported funct -> EXEC; beq 0x04 -> BRANCH; addi 0x08 -> ADDIEX; j 0x02 -> JUMP; otherwise FETCH with illegal_op=1.
REQ-022 Supported funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw -> MEMRD, sw -> MEMWR.
REQ-024 MEMRD: IorD=1, MemRead=1; hold until mem_ready, then MEMWB.
REQ-025 MEMWB: MemtoReg=1, RegWrite=1, instr_done=1; -> FETCH.
REQ-026 MEMWR: IorD=1, MemWrite=1 held until mem_ready; on mem_ready instr_done=1, -> FETCH.
REQ-027 EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtrl per REQ-022 funct mapping; -> ALUWB.
REQ-028 ALUWB: RegDst=1, RegWrite=1, instr_done=1; -> FETCH.
REQ-029 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl SUB, PCSrc=01, Branch=1 (pc_en = Zero), instr_done=1; -> FETCH.
REQ-030 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD; -> ADDIWB. ADDIWB: RegWrite=1, instr_done=1; -> FETCH.
REQ-031 JUMP: PCSrc=10, pc_en=1, instr_done=1; -> FETCH.
REQ-032 opcode/funct SHALL be sampled only in DECODE, MEMADR and EXEC; changes elsewhere have no effect.
REQ-033 CPI: R/addi/beq/j/sw SHALL take 4/4/3/3/4 cycles, lw 5, with zero memory wait; each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds one.

Reset
REQ-034 rst high at a clock edge SHALL force state=FETCH, regardless of current state, including mid-memory-wait.
REQ-035 While rst is high, pc_en, IRWrite, RegWrite, MemWrite, illegal_op, instr_done SHALL be 0; other outputs take FETCH values.
REQ-036 First FETCH after rst deasserts SHALL behave per REQ-020 with no extra cycle.

Verification
REQ-037 add (op 0x00, funct 0x20), mem_ready=1 -> states 0,1,6,7,0; ALUCtrl 0010 in EXEC; RegWrite=1, RegDst=1 only in ALUWB.
REQ-038 lw with mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; IorD=1 throughout MEMRD; instr_done once.
REQ-039 beq with Zero=1 then Zero=0 -> pc_en=1 in BRANCH first case, 0 in second; ALUCtrl 0110.
REQ-040 opcode 0x3F, and R-type funct 0x18 -> DECODE then FETCH, illegal_op=1 for exactly one cycle, no write enable asserted.
REQ-041 rst asserted in MEMWR with mem_ready=0 -> next state FETCH, MemWrite=0 during rst.
REQ-042 slt, sll, srl, or, and sweep -> ALUCtrl 0111, 0100, 0101, 0001, 0000 in EXEC respectively.
